// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and constants for the EX-stage branch resolution block.
package fv_branch_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b011,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BLTU = 3'b110,
        BGE  = 3'b101,
        BGEU = 3'b111
    } bctrl_e;

    typedef enum logic {
        IDLE,
        REDIRECT
    } brc_state_e;

    // Reset value of every history counter: weakly not-taken.
    localparam logic [1:0] BHT_RST = 2'b01;

    // True for the six conditional-branch encodings; 000 and 010 are not branches.
    function automatic logic is_branch(input bctrl_e b);
        case (b)
            BEQ, BNE, BLT, BLTU, BGE, BGEU: is_branch = 1'b1;
            default:                        is_branch = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_bht.sv
// Branch history table: 2-bit saturating counters, one combinational read
// port (old value on same-index update) and one synchronous update port.
module branch_bht
    import fv_branch_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    logic [1:0] ctr_q [2**IDX_W];

    assign rd_taken_o = ctr_q[rd_idx_i][1];

    // Counter array: reset to weakly not-taken, saturating +1/-1 on update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2**IDX_W; i++) begin
                ctr_q[i] <= BHT_RST;
            end
        end else if (upd_en_i) begin
            if (upd_taken_i) begin
                if (ctr_q[upd_idx_i] != 2'b11) ctr_q[upd_idx_i] <= ctr_q[upd_idx_i] + 2'b01;
            end else begin
                if (ctr_q[upd_idx_i] != 2'b00) ctr_q[upd_idx_i] <= ctr_q[upd_idx_i] - 2'b01;
            end
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution: condition compare, mispredict redirect FSM,
// statistics counters. Optional BHT built when FV_BHT_EN is defined;
// otherwise fetch prediction is static not-taken.
module branch_resolve_ctrl
    import fv_branch_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_IDX_W = 6,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [2:0]       ex_bctrl,
    input  logic [XLEN-1:0]  ex_r1,
    input  logic [XLEN-1:0]  ex_r2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    input  logic             redirect_ready,
    output logic             flush_front,
    output logic             stall_ex,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispred
);

    brc_state_e        state_q, state_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]  branches_q, mispred_q;
    bctrl_e            bc;
    logic              taken, resolve, mispredict;
    logic [XLEN-1:0]   target;

    assign bc = bctrl_e'(ex_bctrl);

    // Branch condition evaluation.
    always_comb begin
        taken = 1'b0;
        case (bc)
            BEQ:     taken = (ex_r1 == ex_r2);
            BNE:     taken = (ex_r1 != ex_r2);
            BLT:     taken = ($signed(ex_r1) <  $signed(ex_r2));
            BGE:     taken = ($signed(ex_r1) >= $signed(ex_r2));
            BLTU:    taken = (ex_r1 <  ex_r2);
            BGEU:    taken = (ex_r1 >= ex_r2);
            default: taken = 1'b0;
        endcase
    end

    assign resolve    = (state_q == IDLE) && ex_valid && is_branch(bc);
    assign mispredict = resolve && (taken != ex_pred_taken);
    assign target     = taken ? (ex_pc + ex_imm) : (ex_pc + XLEN'(4));

    // FSM state and held redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // FSM next state and redirect/flush/stall outputs.
    always_comb begin
        state_d        = state_q;
        redirect_pc_d  = redirect_pc_q;
        redirect_valid = 1'b0;
        flush_front    = 1'b0;
        stall_ex       = 1'b0;
        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d       = REDIRECT;
                    redirect_pc_d = target;
                end
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                flush_front    = 1'b1;
                stall_ex       = 1'b1;
                if (redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign redirect_pc = redirect_pc_q;

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branches_q <= '0;
            mispred_q  <= '0;
        end else begin
            if (resolve && (branches_q != '1))   branches_q <= branches_q + 1'b1;
            if (mispredict && (mispred_q != '1)) mispred_q  <= mispred_q + 1'b1;
        end
    end

    assign stat_branches = branches_q;
    assign stat_mispred  = mispred_q;

`ifdef FV_BHT_EN
    logic unused_if_bits;
    assign unused_if_bits = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0]};

    branch_bht #(
        .IDX_W(BHT_IDX_W)
    ) u_bht (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (if_pc[BHT_IDX_W+1:2]),
        .rd_taken_o  (if_pred_taken),
        .upd_en_i    (resolve),
        .upd_idx_i   (ex_pc[BHT_IDX_W+1:2]),
        .upd_taken_i (taken)
    );
`else
    logic unused_if_bits;
    assign unused_if_bits = ^if_pc;
    assign if_pred_taken  = 1'b0;
`endif

endmodule
